// File: rtl/pulse_train.sv
// pulse_train: programmable burst generator.
//
// A start request is accepted while idle with a non-zero count. The block
// then waits DLY cycles, emits count pulses of LEN cycles high separated by
// GAP cycles low, and strobes done for one cycle on normal completion.
// abort terminates a burst without done. A start with count==0 produces a
// done strobe only.
//
// State table:
//   state | meaning
//   IDLE  | waiting for start; busy=0
//   DELAY | initial wait of DLY cycles before the first pulse
//   HIGH  | pulse output high for LEN cycles
//   LOW   | gap between pulses, GAP cycles low
//
// Ports:
//   clk    in   1      clock, all logic on posedge
//   rst    in   1      synchronous reset, active-high
//   start  in   1      burst request, sampled only while idle
//   count  in   CNT_W  pulses per burst, latched on acceptance
//   abort  in   1      terminate the current burst
//   busy   out  1      burst in progress (registered)
//   pulse  out  1      generated pulse (registered)
//   done   out  1      one-cycle completion strobe (registered)

module pulse_train #(
    parameter int DLY   = 3,
    parameter int LEN   = 2,
    parameter int GAP   = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    input  logic             abort,
    output logic             busy,
    output logic             pulse,
    output logic             done
);

    localparam int MAX_DL = (DLY > LEN) ? DLY : LEN;
    localparam int MAX_PH = (MAX_DL > GAP) ? MAX_DL : GAP;
    localparam int PH_W   = $clog2(MAX_PH + 1);

    // Phase counter is a down-counter that terminates at zero, so each
    // phase loads its length minus one.
    localparam logic [PH_W-1:0] DLY_LD = (DLY > 0) ? PH_W'(DLY - 1) : '0;
    localparam logic [PH_W-1:0] LEN_LD = PH_W'(LEN - 1);
    localparam logic [PH_W-1:0] GAP_LD = PH_W'(GAP - 1);

    generate
        if (LEN < 1 || GAP < 1) begin : g_bad_param
            $error("pulse_train: LEN and GAP must both be at least 1");
        end
        if (DLY < 0) begin : g_bad_dly
            $error("pulse_train: DLY must be non-negative");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    state_t           state;
    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] remaining;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            phase     <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            pulse     <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    // abort while idle is a no-op but still blocks a start
                    if (start && !abort) begin
                        if (count == '0) begin
                            done <= 1'b1;
                        end else begin
                            remaining <= count;
                            busy      <= 1'b1;
                            if (DLY == 0) begin
                                state <= HIGH;
                                phase <= LEN_LD;
                                pulse <= 1'b1;
                            end else begin
                                state <= DELAY;
                                phase <= DLY_LD;
                            end
                        end
                    end
                end

                DELAY: begin
                    if (abort) begin
                        state     <= IDLE;
                        phase     <= '0;
                        remaining <= '0;
                        busy      <= 1'b0;
                        pulse     <= 1'b0;
                    end else if (phase == '0) begin
                        state <= HIGH;
                        phase <= LEN_LD;
                        pulse <= 1'b1;
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end

                HIGH: begin
                    if (abort) begin
                        state     <= IDLE;
                        phase     <= '0;
                        remaining <= '0;
                        busy      <= 1'b0;
                        pulse     <= 1'b0;
                    end else if (phase == '0) begin
                        pulse <= 1'b0;
                        // remaining is decremented here; a value of one means
                        // this was the last pulse of the burst
                        if (remaining == CNT_W'(1)) begin
                            state     <= IDLE;
                            remaining <= '0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                        end else begin
                            state     <= LOW;
                            remaining <= remaining - 1'b1;
                            phase     <= GAP_LD;
                        end
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end

                LOW: begin
                    if (abort) begin
                        state     <= IDLE;
                        phase     <= '0;
                        remaining <= '0;
                        busy      <= 1'b0;
                        pulse     <= 1'b0;
                    end else if (phase == '0) begin
                        state <= HIGH;
                        phase <= LEN_LD;
                        pulse <= 1'b1;
                    end else begin
                        phase <= phase - 1'b1;
                    end
                end

                default: begin
                    state     <= IDLE;
                    phase     <= '0;
                    remaining <= '0;
                    busy      <= 1'b0;
                    pulse     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_train.sv
// Testbench for pulse_train: two instances (DLY=3 and DLY=0) share one
// stimulus stream. After every edge a timeline model derives the expected
// {busy,pulse,done} from the burst start edge and plain arithmetic, pushes it
// into a per-instance queue, and a monitor pops and compares on the negedge.

module tb_pulse_train;

    localparam int LEN = 2;
    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] count = 8'd0;
    logic       abort = 1'b0;

    logic busy_a, pulse_a, done_a;
    logic busy_b, pulse_b, done_b;

    always #5 clk = ~clk;

    pulse_train #(.DLY(3), .LEN(LEN), .GAP(GAP), .CNT_W(8)) dut_a (
        .clk(clk), .rst(rst), .start(start), .count(count), .abort(abort),
        .busy(busy_a), .pulse(pulse_a), .done(done_a)
    );

    pulse_train #(.DLY(0), .LEN(LEN), .GAP(GAP), .CNT_W(8)) dut_b (
        .clk(clk), .rst(rst), .start(start), .count(count), .abort(abort),
        .busy(busy_b), .pulse(pulse_b), .done(done_b)
    );

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;

    // model state per instance: active flag, start edge, burst length in cycles
    int act [2];
    int kst [2];
    int tot [2];

    logic [2:0] q_a [$];
    logic [2:0] q_b [$];

    task automatic model(input int i, input int dly, output logic [2:0] e);
        int t;
        int u;
        int n;
        e = 3'b000;
        if (rst) begin
            act[i] = 0;
        end else if (act[i] != 0) begin
            if (abort) begin
                act[i] = 0;
            end else begin
                t = ecnt - kst[i];
                if (t == tot[i]) begin
                    act[i] = 0;
                    e = 3'b001;
                end else begin
                    e[2] = 1'b1;
                    u = t - dly;
                    if (u >= 0 && (u % (LEN + GAP)) < LEN) e[1] = 1'b1;
                end
            end
        end else if (start && !abort) begin
            n = int'(count);
            if (n == 0) begin
                e = 3'b001;
            end else begin
                act[i] = 1;
                kst[i] = ecnt;
                tot[i] = dly + n * LEN + (n - 1) * GAP;
                e[2] = 1'b1;
                if (dly == 0) e[1] = 1'b1;
            end
        end
    endtask

    task automatic tick();
        logic [2:0] ea;
        logic [2:0] eb;
        @(posedge clk);
        model(0, 3, ea);
        model(1, 0, eb);
        q_a.push_back(ea);
        q_b.push_back(eb);
        ecnt++;
        #1;
    endtask

    task automatic cyc(input logic s, input logic [7:0] c, input logic a, input logic r);
        start = s;
        count = c;
        abort = a;
        rst   = r;
        tick();
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) cyc(1'b0, 8'd0, 1'b0, 1'b0);
    endtask

    always @(negedge clk) begin
        logic [2:0] exp_v;
        if (q_a.size() > 0) begin
            exp_v = q_a.pop_front();
            total++;
            if ({busy_a, pulse_a, done_a} !== exp_v) begin
                bad++;
                $display("FAIL dly3_outputs edge=%0d busy/pulse/done got=%b required=%b",
                         ecnt - 1, {busy_a, pulse_a, done_a}, exp_v);
            end
        end
        if (q_b.size() > 0) begin
            exp_v = q_b.pop_front();
            total++;
            if ({busy_b, pulse_b, done_b} !== exp_v) begin
                bad++;
                $display("FAIL dly0_outputs edge=%0d busy/pulse/done got=%b required=%b",
                         ecnt - 1, {busy_b, pulse_b, done_b}, exp_v);
            end
        end
    end

    initial begin
        act[0] = 0; act[1] = 0;
        kst[0] = 0; kst[1] = 0;
        tot[0] = 0; tot[1] = 0;

        // reset
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        idle(2);

        // single pulse
        cyc(1'b1, 8'd1, 1'b0, 1'b0);
        idle(8);

        // three pulses
        cyc(1'b1, 8'd3, 1'b0, 1'b0);
        idle(16);

        // zero count: done only
        cyc(1'b1, 8'd0, 1'b0, 1'b0);
        idle(3);

        // abort during the second pulse, then an immediate new start
        cyc(1'b1, 8'd3, 1'b0, 1'b0);
        idle(8);
        cyc(1'b0, 8'd0, 1'b1, 1'b0);
        cyc(1'b1, 8'd2, 1'b0, 1'b0);
        idle(20);

        // abort while idle suppresses start
        cyc(1'b1, 8'd2, 1'b1, 1'b0);
        idle(3);

        // start and count churn while busy, then back-to-back restart
        cyc(1'b1, 8'd2, 1'b0, 1'b0);
        for (int j = 0; j < 8; j++) cyc(1'b1, 8'd7, 1'b0, 1'b0);
        cyc(1'b1, 8'd2, 1'b0, 1'b0);
        cyc(1'b1, 8'd2, 1'b0, 1'b0);
        idle(30);

        // reset mid-burst
        cyc(1'b1, 8'd3, 1'b0, 1'b0);
        idle(5);
        cyc(1'b0, 8'd0, 1'b0, 1'b1);
        idle(15);

        // randomized traffic
        for (int j = 0; j < 3000; j++) begin
            cyc(($urandom_range(0, 3) == 0),
                8'($urandom_range(0, 5)),
                ($urandom_range(0, 39) == 0),
                ($urandom_range(0, 199) == 0));
        end
        idle(40);

        @(negedge clk);
        #1;
        total++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d/%0d required=0/0", q_a.size(), q_b.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
